// File: rtl/if_pkg.sv
// Shared types and default sizes for the instruction-fetch stage with prefetch queue.
package if_pkg;

   localparam int unsigned LARGURA_PADRAO    = 32;
   localparam int unsigned INCREMENTO_PADRAO = 4;

   typedef enum logic [1:0] {
      OCIOSO,
      AGUARDA,
      DESCARTA
   } estado_t;

endpackage

// File: rtl/if_fila.sv
// Circular FIFO holding {pc, instruction} pairs between the fetch FSM and decode.
module if_fila
   import if_pkg::*;
#(
   parameter  int unsigned DADOS        = 64,
   parameter  int unsigned PROFUNDIDADE = 4,
   localparam int unsigned AW           = $clog2(PROFUNDIDADE),
   localparam int unsigned CW           = AW + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [DADOS-1:0] dado_i,
   output logic [DADOS-1:0] dado_o,
   output logic             cheia_o,
   output logic             vazia_o,
   output logic [CW-1:0]    ocupacao_o
);

   logic [DADOS-1:0] mem_q [PROFUNDIDADE];
   logic [AW-1:0]    wrPtr_q;
   logic [AW-1:0]    rdPtr_q;
   logic [CW-1:0]    count_q;
   logic             pushOk;
   logic             popOk;

   assign vazia_o    = (count_q == '0);
   assign cheia_o    = (count_q == CW'(PROFUNDIDADE));
   assign ocupacao_o = count_q;
   assign dado_o     = mem_q[rdPtr_q];

   // A push into a full queue is only accepted when the head leaves in the same cycle.
   assign popOk  = pop_i & ~vazia_o;
   assign pushOk = push_i & (~cheia_o | popOk);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (pushOk) wrPtr_q <= wrPtr_q + AW'(1);
         if (popOk)  rdPtr_q <= rdPtr_q + AW'(1);
         count_q <= count_q + CW'(pushOk) - CW'(popOk);
      end
   end

   always_ff @(posedge clock) begin
      if (pushOk & ~flush_i) mem_q[wrPtr_q] <= dado_i;
   end

endmodule

// File: rtl/if_fila_busca.sv
// Instruction-fetch stage: PC register, adder, redirect mux, single-outstanding fetch FSM
// and a prefetch queue feeding decode.
module if_fila_busca
   import if_pkg::*;
#(
   parameter int unsigned        LARGURA      = LARGURA_PADRAO,
   parameter int unsigned        PROFUNDIDADE = 4,
   parameter logic [LARGURA-1:0] PC_RESET     = '0,
   parameter int unsigned        INCREMENTO   = INCREMENTO_PADRAO
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               controle,
   input  logic [LARGURA-1:0] entradaMux,
   input  logic               PCescreve,
   output logic               mem_req,
   output logic [LARGURA-1:0] mem_addr,
   input  logic               mem_ack,
   input  logic [LARGURA-1:0] mem_dado,
   output logic               saida_valida,
   output logic [LARGURA-1:0] saida_instr,
   output logic [LARGURA-1:0] saida_pc,
   output logic [LARGURA-1:0] Pcsaida,
   output logic [LARGURA-1:0] saidaAdder
);

   localparam int unsigned        CW     = $clog2(PROFUNDIDADE) + 1;
   localparam logic [CW:0]        LIMITE = (CW + 1)'(PROFUNDIDADE);
   localparam logic [LARGURA-1:0] PASSO  = LARGURA'(INCREMENTO);

   estado_t              estado_q;
   logic                 memReq_q;
   logic [LARGURA-1:0]   memAddr_q;
   logic [LARGURA-1:0]   pc_q;
   logic [LARGURA-1:0]   pcMais;
   logic [2*LARGURA-1:0] cabeca;
   logic                 vazia;
   logic                 cheia;
   logic [CW-1:0]        ocupacao;
   logic                 desenfileira;
   logic                 enfileira;
   logic [CW:0]          ocupAposSaida;
   logic [CW:0]          ocupAposCiclo;

   assign pcMais = pc_q + PASSO;

   // A redirect suppresses both queue movements; the flush wins in that cycle.
   assign desenfileira  = ~vazia & PCescreve & ~controle;
   assign enfileira     = (estado_q == AGUARDA) & mem_ack & ~controle & (~cheia | desenfileira);
   assign ocupAposSaida = {1'b0, ocupacao} - (CW + 1)'(desenfileira);
   assign ocupAposCiclo = ocupAposSaida + (CW + 1)'(enfileira);

   if_fila #(
      .DADOS        (2 * LARGURA),
      .PROFUNDIDADE (PROFUNDIDADE)
   ) u_fila (
      .clock      (clock),
      .reset      (reset),
      .push_i     (enfileira),
      .pop_i      (desenfileira),
      .flush_i    (controle),
      .dado_i     ({memAddr_q, mem_dado}),
      .dado_o     (cabeca),
      .cheia_o    (cheia),
      .vazia_o    (vazia),
      .ocupacao_o (ocupacao)
   );

   assign saida_valida = ~vazia;
   assign saida_pc     = vazia ? '0 : cabeca[2*LARGURA-1:LARGURA];
   assign saida_instr  = vazia ? '0 : cabeca[LARGURA-1:0];
   assign mem_req      = memReq_q;
   assign mem_addr     = memAddr_q;
   assign Pcsaida      = pc_q;
   assign saidaAdder   = pcMais;

   // Pcsaida tracks the address in flight while AGUARDA, so an ack simply advances it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q  <= OCIOSO;
         memReq_q  <= 1'b0;
         memAddr_q <= PC_RESET;
         pc_q      <= PC_RESET;
      end else if (controle) begin
         pc_q <= entradaMux;
         if (estado_q != OCIOSO) begin
            if (mem_ack) begin
               estado_q <= OCIOSO;
               memReq_q <= 1'b0;
            end else begin
               estado_q <= DESCARTA;
            end
         end
      end else begin
         case (estado_q)
            OCIOSO: begin
               if (ocupAposSaida < LIMITE) begin
                  estado_q  <= AGUARDA;
                  memReq_q  <= 1'b1;
                  memAddr_q <= pc_q;
               end
            end
            AGUARDA: begin
               if (mem_ack) begin
                  pc_q <= pcMais;
                  if (ocupAposCiclo < LIMITE) begin
                     memAddr_q <= pcMais;
                  end else begin
                     estado_q <= OCIOSO;
                     memReq_q <= 1'b0;
                  end
               end
            end
            DESCARTA: begin
               if (mem_ack) begin
                  estado_q <= OCIOSO;
                  memReq_q <= 1'b0;
               end
            end
            default: begin
               estado_q <= OCIOSO;
               memReq_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fila_busca.sv
// Scoreboard bench for if_fila_busca: expected PCs are queued as stimulus is planned and
// checked as decode consumes the queue head.
module tb_if_fila_busca;

   logic        clock;
   logic        reset;
   logic        controle;
   logic [31:0] entradaMux;
   logic        PCescreve;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_dado;
   logic        saida_valida;
   logic [31:0] saida_instr;
   logic [31:0] saida_pc;
   logic [31:0] Pcsaida;
   logic [31:0] saidaAdder;

   logic        resetW;
   logic        controleW;
   logic [31:0] entradaMuxW;
   logic        PCescreveW;
   logic        mem_reqW;
   logic [31:0] mem_addrW;
   logic        mem_ackW;
   logic [31:0] mem_dadoW;
   logic        saida_validaW;
   logic [31:0] saida_instrW;
   logic [31:0] saida_pcW;
   logic [31:0] PcsaidaW;
   logic [31:0] saidaAdderW;

   int          vecs;
   int          erros;
   int          latencia;
   int          espera;
   logic [31:0] esperado[$];

   if_fila_busca u_dut (
      .clock        (clock),
      .reset        (reset),
      .controle     (controle),
      .entradaMux   (entradaMux),
      .PCescreve    (PCescreve),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_dado     (mem_dado),
      .saida_valida (saida_valida),
      .saida_instr  (saida_instr),
      .saida_pc     (saida_pc),
      .Pcsaida      (Pcsaida),
      .saidaAdder   (saidaAdder)
   );

   if_fila_busca #(.PC_RESET(32'hFFFF_FFF8)) u_dut_wrap (
      .clock        (clock),
      .reset        (resetW),
      .controle     (controleW),
      .entradaMux   (entradaMuxW),
      .PCescreve    (PCescreveW),
      .mem_req      (mem_reqW),
      .mem_addr     (mem_addrW),
      .mem_ack      (mem_ackW),
      .mem_dado     (mem_dadoW),
      .saida_valida (saida_validaW),
      .saida_instr  (saida_instrW),
      .saida_pc     (saida_pcW),
      .Pcsaida      (PcsaidaW),
      .saidaAdder   (saidaAdderW)
   );

   function automatic logic [31:0] instrDe(input logic [31:0] pc);
      return {pc[15:0], pc[31:16]} ^ 32'hA5C3_0F1E;
   endfunction

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction memory: acks after 'latencia' waiting cycles, each back-to-back request counted afresh.
   always @(negedge clock) begin
      if (reset || !mem_req) begin
         mem_ack = 1'b0;
         espera  = 0;
      end else begin
         if (mem_ack) espera = 0;
         if (espera >= latencia) begin
            mem_ack  = 1'b1;
            mem_dado = instrDe(mem_addr);
         end else begin
            mem_ack = 1'b0;
            espera  = espera + 1;
         end
      end
   end

   // Zero-wait memory for the wrap-around instance.
   always @(negedge clock) begin
      if (resetW || !mem_reqW) begin
         mem_ackW = 1'b0;
      end else begin
         mem_ackW  = 1'b1;
         mem_dadoW = instrDe(mem_addrW);
      end
   end

   task automatic doReset();
      reset      = 1'b1;
      controle   = 1'b0;
      PCescreve  = 1'b0;
      entradaMux = '0;
      latencia   = 0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      esperado.delete();
   endtask

   task automatic test_reset();
      bit viuReq;
      #2 reset = 1'b1;
      #1;
      vecs++; if (mem_req !== 1'b0) begin erros++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
      vecs++; if (mem_addr !== 32'h0) begin erros++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
      vecs++; if (saida_valida !== 1'b0) begin erros++; $display("[TB] FAIL reset_valida: got %b expected 0", saida_valida); end
      vecs++; if (saida_pc !== 32'h0) begin erros++; $display("[TB] FAIL reset_saida_pc: got %h expected 0", saida_pc); end
      vecs++; if (saida_instr !== 32'h0) begin erros++; $display("[TB] FAIL reset_saida_instr: got %h expected 0", saida_instr); end
      vecs++; if (Pcsaida !== 32'h0) begin erros++; $display("[TB] FAIL reset_Pcsaida: got %h expected 0", Pcsaida); end
      vecs++; if (saidaAdder !== 32'h4) begin erros++; $display("[TB] FAIL reset_saidaAdder: got %h expected 4", saidaAdder); end
      doReset();
      viuReq = 1'b0;
      for (int c = 0; c < 5 && !viuReq; c++) begin
         @(negedge clock);
         if (mem_req) viuReq = 1'b1;
      end
      vecs++;
      if (!viuReq) begin
         erros++; $display("[TB] FAIL reset_first_req: got no request expected one within 5 cycles");
      end else if (mem_addr !== 32'h0) begin
         erros++; $display("[TB] FAIL reset_first_addr: got %h expected 0", mem_addr);
      end
   endtask

   task automatic test_sequencial();
      logic [31:0] alvo;
      int primeiro;
      int ultimo;
      doReset();
      PCescreve = 1'b1;
      for (int i = 0; i < 8; i++) esperado.push_back(32'(4 * i));
      primeiro = -1;
      ultimo   = -1;
      for (int c = 0; c < 60 && esperado.size() > 0; c++) begin
         @(negedge clock);
         if (saida_valida && PCescreve) begin
            alvo = esperado.pop_front();
            if (primeiro < 0) primeiro = c;
            ultimo = c;
            vecs++; if (saida_pc !== alvo) begin erros++; $display("[TB] FAIL seq_pc: got %h expected %h", saida_pc, alvo); end
            vecs++; if (saida_instr !== instrDe(alvo)) begin erros++; $display("[TB] FAIL seq_instr: got %h expected %h", saida_instr, instrDe(alvo)); end
         end
      end
      vecs++; if (esperado.size() != 0) begin erros++; $display("[TB] FAIL seq_timeout: got %0d left expected 0", esperado.size()); end
      vecs++; if (ultimo - primeiro != 7) begin erros++; $display("[TB] FAIL seq_throughput: got %0d cycles expected 7", ultimo - primeiro); end
   endtask

   task automatic test_stall();
      logic [31:0] alvo;
      doReset();
      repeat (15) @(negedge clock);
      vecs++; if (saida_valida !== 1'b1) begin erros++; $display("[TB] FAIL stall_valida: got %b expected 1", saida_valida); end
      vecs++; if (saida_pc !== 32'h0) begin erros++; $display("[TB] FAIL stall_head_pc: got %h expected 0", saida_pc); end
      vecs++; if (saida_instr !== instrDe(32'h0)) begin erros++; $display("[TB] FAIL stall_head_instr: got %h expected %h", saida_instr, instrDe(32'h0)); end
      vecs++; if (mem_req !== 1'b0) begin erros++; $display("[TB] FAIL stall_mem_req: got %b expected 0", mem_req); end
      vecs++; if (Pcsaida !== 32'h10) begin erros++; $display("[TB] FAIL stall_Pcsaida: got %h expected 10", Pcsaida); end
      vecs++; if (saidaAdder !== 32'h14) begin erros++; $display("[TB] FAIL stall_saidaAdder: got %h expected 14", saidaAdder); end
      for (int i = 0; i < 6; i++) esperado.push_back(32'(4 * i));
      PCescreve = 1'b1;
      for (int c = 0; c < 40 && esperado.size() > 0; c++) begin
         if (saida_valida && PCescreve) begin
            alvo = esperado.pop_front();
            vecs++; if (saida_pc !== alvo) begin erros++; $display("[TB] FAIL stall_drain_pc: got %h expected %h", saida_pc, alvo); end
            vecs++; if (saida_instr !== instrDe(alvo)) begin erros++; $display("[TB] FAIL stall_drain_instr: got %h expected %h", saida_instr, instrDe(alvo)); end
         end
         @(negedge clock);
      end
      vecs++; if (esperado.size() != 0) begin erros++; $display("[TB] FAIL stall_timeout: got %0d left expected 0", esperado.size()); end
   endtask

   task automatic test_redirect_ocioso();
      logic [31:0] alvo;
      doReset();
      repeat (15) @(negedge clock);
      controle   = 1'b1;
      entradaMux = 32'h40;
      PCescreve  = 1'b1;
      @(negedge clock);
      controle  = 1'b0;
      PCescreve = 1'b0;
      vecs++; if (saida_valida !== 1'b0) begin erros++; $display("[TB] FAIL redir_idle_valida: got %b expected 0", saida_valida); end
      vecs++; if (Pcsaida !== 32'h40) begin erros++; $display("[TB] FAIL redir_idle_Pcsaida: got %h expected 40", Pcsaida); end
      vecs++; if (mem_req !== 1'b0) begin erros++; $display("[TB] FAIL redir_idle_early_req: got %b expected 0", mem_req); end
      @(negedge clock);
      vecs++; if (mem_req !== 1'b1) begin erros++; $display("[TB] FAIL redir_idle_req: got %b expected 1", mem_req); end
      vecs++; if (mem_addr !== 32'h40) begin erros++; $display("[TB] FAIL redir_idle_addr: got %h expected 40", mem_addr); end
      esperado.push_back(32'h40);
      esperado.push_back(32'h44);
      esperado.push_back(32'h48);
      PCescreve = 1'b1;
      for (int c = 0; c < 40 && esperado.size() > 0; c++) begin
         @(negedge clock);
         if (saida_valida && PCescreve) begin
            alvo = esperado.pop_front();
            vecs++; if (saida_pc !== alvo) begin erros++; $display("[TB] FAIL redir_idle_pc: got %h expected %h", saida_pc, alvo); end
            vecs++; if (saida_instr !== instrDe(alvo)) begin erros++; $display("[TB] FAIL redir_idle_instr: got %h expected %h", saida_instr, instrDe(alvo)); end
         end
      end
      vecs++; if (esperado.size() != 0) begin erros++; $display("[TB] FAIL redir_idle_timeout: got %0d left expected 0", esperado.size()); end
   endtask

   task automatic test_redirect_pendente();
      logic [31:0] alvo;
      bit achou;
      int ciclos;
      doReset();
      latencia = 3;
      achou = 1'b0;
      for (int c = 0; c < 50 && !achou; c++) begin
         @(negedge clock);
         if (mem_req && mem_addr == 32'h8) achou = 1'b1;
      end
      vecs++;
      if (!achou) begin
         erros++; $display("[TB] FAIL redir_pend_setup: got no request for 8 expected one within 50 cycles");
      end else begin
         controle   = 1'b1;
         entradaMux = 32'h40;
         @(negedge clock);
         controle = 1'b0;
         ciclos = 0;
         while (mem_req && ciclos < 20) begin
            vecs++; if (mem_addr !== 32'h8) begin erros++; $display("[TB] FAIL redir_pend_addr_held: got %h expected 8", mem_addr); end
            vecs++; if (saida_valida !== 1'b0) begin erros++; $display("[TB] FAIL redir_pend_valida: got %b expected 0", saida_valida); end
            ciclos++;
            @(negedge clock);
         end
         vecs++; if (mem_req !== 1'b0) begin erros++; $display("[TB] FAIL redir_pend_timeout: got req %b expected 0 within 20 cycles", mem_req); end
         vecs++; if (Pcsaida !== 32'h40) begin erros++; $display("[TB] FAIL redir_pend_Pcsaida: got %h expected 40", Pcsaida); end
         @(negedge clock);
         vecs++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin erros++; $display("[TB] FAIL redir_pend_next_req: got req %b addr %h expected 1 and 40", mem_req, mem_addr); end
         esperado.push_back(32'h40);
         esperado.push_back(32'h44);
         PCescreve = 1'b1;
         for (int c = 0; c < 40 && esperado.size() > 0; c++) begin
            @(negedge clock);
            if (saida_valida && PCescreve) begin
               alvo = esperado.pop_front();
               vecs++; if (saida_pc !== alvo) begin erros++; $display("[TB] FAIL redir_pend_pc: got %h expected %h", saida_pc, alvo); end
               vecs++; if (saida_instr !== instrDe(alvo)) begin erros++; $display("[TB] FAIL redir_pend_instr: got %h expected %h", saida_instr, instrDe(alvo)); end
            end
         end
         vecs++; if (esperado.size() != 0) begin erros++; $display("[TB] FAIL redir_pend_drain_timeout: got %0d left expected 0", esperado.size()); end
      end
   endtask

   task automatic test_reset_assincrono();
      logic [31:0] alvo;
      doReset();
      latencia = 2;
      repeat (8) @(negedge clock);
      vecs++; if (saida_valida !== 1'b1) begin erros++; $display("[TB] FAIL areset_pre_valida: got %b expected 1", saida_valida); end
      #2 reset = 1'b1;
      #1;
      vecs++; if (mem_req !== 1'b0) begin erros++; $display("[TB] FAIL areset_mem_req: got %b expected 0", mem_req); end
      vecs++; if (saida_valida !== 1'b0) begin erros++; $display("[TB] FAIL areset_valida: got %b expected 0", saida_valida); end
      vecs++; if (Pcsaida !== 32'h0) begin erros++; $display("[TB] FAIL areset_Pcsaida: got %h expected 0", Pcsaida); end
      vecs++; if (mem_addr !== 32'h0) begin erros++; $display("[TB] FAIL areset_mem_addr: got %h expected 0", mem_addr); end
      doReset();
      PCescreve = 1'b1;
      for (int i = 0; i < 3; i++) esperado.push_back(32'(4 * i));
      for (int c = 0; c < 40 && esperado.size() > 0; c++) begin
         @(negedge clock);
         if (saida_valida && PCescreve) begin
            alvo = esperado.pop_front();
            vecs++; if (saida_pc !== alvo) begin erros++; $display("[TB] FAIL areset_restart_pc: got %h expected %h", saida_pc, alvo); end
            vecs++; if (saida_instr !== instrDe(alvo)) begin erros++; $display("[TB] FAIL areset_restart_instr: got %h expected %h", saida_instr, instrDe(alvo)); end
         end
      end
      vecs++; if (esperado.size() != 0) begin erros++; $display("[TB] FAIL areset_timeout: got %0d left expected 0", esperado.size()); end
   endtask

   task automatic test_wrap();
      logic [31:0] alvo;
      PCescreve = 1'b0;
      @(negedge clock);
      vecs++; if (PcsaidaW !== 32'hFFFF_FFF8) begin erros++; $display("[TB] FAIL wrap_reset_Pcsaida: got %h expected fffffff8", PcsaidaW); end
      vecs++; if (saidaAdderW !== 32'hFFFF_FFFC) begin erros++; $display("[TB] FAIL wrap_reset_adder: got %h expected fffffffc", saidaAdderW); end
      esperado.delete();
      esperado.push_back(32'hFFFF_FFF8);
      esperado.push_back(32'hFFFF_FFFC);
      esperado.push_back(32'h0000_0000);
      esperado.push_back(32'h0000_0004);
      resetW     = 1'b0;
      PCescreveW = 1'b1;
      for (int c = 0; c < 40 && esperado.size() > 0; c++) begin
         @(negedge clock);
         if (saida_validaW && PCescreveW) begin
            alvo = esperado.pop_front();
            vecs++; if (saida_pcW !== alvo) begin erros++; $display("[TB] FAIL wrap_pc: got %h expected %h", saida_pcW, alvo); end
            vecs++; if (saida_instrW !== instrDe(alvo)) begin erros++; $display("[TB] FAIL wrap_instr: got %h expected %h", saida_instrW, instrDe(alvo)); end
         end
      end
      vecs++; if (esperado.size() != 0) begin erros++; $display("[TB] FAIL wrap_timeout: got %0d left expected 0", esperado.size()); end
   endtask

   initial begin
      vecs        = 0;
      erros       = 0;
      latencia    = 0;
      espera      = 0;
      reset       = 1'b0;
      controle    = 1'b0;
      entradaMux  = '0;
      PCescreve   = 1'b0;
      mem_ack     = 1'b0;
      mem_dado    = '0;
      resetW      = 1'b0;
      controleW   = 1'b0;
      entradaMuxW = '0;
      PCescreveW  = 1'b0;
      mem_ackW    = 1'b0;
      mem_dadoW   = '0;
      #1 resetW   = 1'b1;
      $display("[TB] starting if_fila_busca bench");
      test_reset();
      test_sequencial();
      test_stall();
      test_redirect_ocioso();
      test_redirect_pendente();
      test_reset_assincrono();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, erros);
      $finish;
   end

endmodule
